// File: rtl/sd_input_skid.sv
// Receiving end of an srdy/drdy channel: a two-entry skid buffer whose outputs
// (c_drdy, ip_srdy, ip_data, usage) all come straight from flops.
module sd_input_skid #(
  parameter int width = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             c_srdy,
  output logic             c_drdy,
  input  logic [width-1:0] c_data,
  output logic             ip_srdy,
  input  logic             ip_drdy,
  output logic [width-1:0] ip_data,
  output logic [1:0]       usage
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t state, nxt_state;

  logic             c_xfer, i_xfer;
  logic             load_hold, hold_from_skid, load_skid;
  logic [width-1:0] hold_q, skid_q;

  assign c_xfer = c_srdy & c_drdy;
  assign i_xfer = ip_srdy & ip_drdy;

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    nxt_state      = state;
    load_hold      = 1'b0;
    hold_from_skid = 1'b0;
    load_skid      = 1'b0;
    case (state)
      ONE: begin
        if (c_xfer && !i_xfer) begin
          nxt_state = FULL;
          load_skid = 1'b1;
        end else if (!c_xfer && i_xfer) begin
          nxt_state = EMPTY;
        end else if (c_xfer && i_xfer) begin
          load_hold = 1'b1;
        end
      end
      FULL: begin
        // c_drdy is low here, so only a drain can happen.
        if (i_xfer) begin
          nxt_state      = ONE;
          load_hold      = 1'b1;
          hold_from_skid = 1'b1;
        end
      end
      default: begin
        // EMPTY, and the unused encoding 3 which recovers as if EMPTY.
        if (c_xfer) begin
          nxt_state = ONE;
          load_hold = 1'b1;
        end else begin
          nxt_state = EMPTY;
        end
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of the order of statements.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= EMPTY;
      c_drdy  <= 1'b1;
      ip_srdy <= 1'b0;
    end else begin
      state   <= nxt_state;
      c_drdy  <= (nxt_state != FULL);
      ip_srdy <= (nxt_state != EMPTY);
    end
  end

  // NOTE: the data registers are deliberately not reset; their contents are
  // qualified by ip_srdy/state, and leaving them unreset keeps reset fan-out low.
  always_ff @(posedge clk) begin
    if (load_hold) hold_q <= hold_from_skid ? skid_q : c_data;
    if (load_skid) skid_q <= c_data;
  end

  assign ip_data = hold_q;
  assign usage   = state;

endmodule
